mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port instr, input, 32 bits: the instruction word, valid while state=FETCH and mem_ready=1.
REQ-004 The block SHALL have port mem_ready, input, 1 bit: the memory handshake, sampled in the FETCH and MEM states.
REQ-005 The block SHALL have port zero, input, 1 bit: the ALU zero flag, sampled in the EXECUTE state.
REQ-006 The block SHALL have port alu_op, output, 4 bits: the ALU operation code, encoded AND=0000, OR=0001, ADD=0010, SUB=0110, LT=0100, SRL=1000, SLL=1001, SRA=1010, XOR=0101.
REQ-007 The block SHALL have port alu_src, output, 1 bit: operand-2 select, where 0=rs2 and 1=immediate.
REQ-008 The block SHALL have output ports ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg and branch_taken, each 1 bit: datapath strobes.
REQ-009 The block SHALL have output ports illegal and retire, each 1 bit: single-cycle status pulses.

Function
REQ-010 The state machine SHALL have the states FETCH, DECODE, EXECUTE, MEM and WB; outputs SHALL be Moore-decoded from the state and the latched instruction register, except branch_taken.
REQ-011 In FETCH, the block SHALL assert mem_read; when mem_ready=1 it SHALL also assert ir_write and pc_write, latch instr into the internal IR and go to DECODE; when mem_ready=0 it SHALL hold FETCH.
REQ-012 DECODE SHALL last exactly one cycle, with every strobe at 0.
REQ-013 In DECODE, a supported opcode (0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ) SHALL go to EXECUTE.
REQ-014 In DECODE, any other opcode, or funct3=011 on R/I-ALU, or funct3≠010 on LW/SW, or funct3≠000 on BEQ, SHALL pulse illegal and go to FETCH.
REQ-015 In EXECUTE, alu_op SHALL be driven from funct3 as follows: 000 gives ADD (SUB if R-type and IR[30]=1), 001 gives SLL, 010 gives LT, 100 gives XOR, 101 gives SRL (SRA if IR[30]=1, for both R-type and I-type), 110 gives OR, 111 gives AND.
REQ-016 In EXECUTE, LW and SW SHALL drive ADD with alu_src=1.
REQ-017 In EXECUTE, BEQ SHALL drive SUB with alu_src=0.
REQ-018 In EXECUTE, I-ALU SHALL drive alu_src=1 and R-type SHALL drive alu_src=0.
REQ-019 On I-ALU funct3=000, IR[30] SHALL be ignored (addi never subtracts).
REQ-020 alu_op SHALL hold its EXECUTE value through MEM and WB, and SHALL be ADD (0010) in FETCH and DECODE.
REQ-021 EXECUTE SHALL transition to WB for R and I-ALU, to MEM for LW and SW, and to FETCH for BEQ.
REQ-022 For BEQ, branch_taken SHALL equal zero combinationally during EXECUTE and SHALL be 0 in every other state.
REQ-023 In MEM, LW SHALL assert mem_read and SW SHALL assert mem_write, held until mem_ready=1.
REQ-024 When MEM completes (mem_ready=1), LW SHALL go to WB and SW SHALL go to FETCH.
REQ-025 In WB, the block SHALL assert reg_write, with mem_to_reg=1 only for LW, and SHALL go to FETCH.
REQ-026 retire SHALL pulse in the final cycle of every legal instruction (WB; MEM of SW; EXECUTE of BEQ), and SHALL not pulse for illegal instructions.
REQ-027 Latency with mem_ready tied high SHALL be R/I 4 cycles, LW 5, SW 4, BEQ 3, illegal 2.
REQ-028 At most one of mem_read, mem_write and reg_write SHALL be high in any cycle.

Reset
REQ-029 When rst=1 at a clock edge, the state SHALL become FETCH, the IR SHALL become 0x00000000, and the block SHALL discard any in-flight instruction, including mid-MEM.
REQ-030 While rst=1, all strobes and pulses SHALL be 0 and alu_op SHALL be 0010.
REQ-031 rst SHALL take priority over mem_ready and every other input in the same cycle.
REQ-032 In the first cycle after rst deasserts, the state SHALL be FETCH with mem_read=1.

Verification
REQ-033 With mem_ready=1 and instr=0x002081B3 (add): alu_op=0010 and alu_src=0 in cycle 3; reg_write=1 and retire=1 in cycle 4; back in FETCH in cycle 5.
REQ-034 Stimulus instr=0x402081B3 (sub) SHALL produce alu_op=0110; stimulus instr=0x4030D293 (srai) SHALL produce alu_op=1010 with alu_src=1.
REQ-035 Stimulus instr=0x00208463 (beq) with zero=1 SHALL produce branch_taken=1, alu_op=0110 and retire=1 in cycle 3; with zero=0, branch_taken SHALL be 0 and retire SHALL still be 1.
REQ-036 Stimulus instr=0x0000A183 (lw) with mem_ready=0 for 3 cycles in MEM SHALL hold MEM with mem_read=1; after mem_ready rises, reg_write=1 and mem_to_reg=1 SHALL follow next cycle (total 8 cycles).
REQ-037 Stimulus instr=0x00000000 SHALL pulse illegal=1 in DECODE, with no reg_write, mem_write or retire, and the next FETCH at cycle 3.
REQ-038 Asserting rst during the MEM state of an SW SHALL produce mem_write=0 in that same cycle and FETCH with IR=0 on the next cycle.

Source files
------------

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle control unit for an RV32I subset (R-type ALU,
//                I-type ALU, LW, SW, BEQ). Sequences FETCH -> DECODE ->
//                EXECUTE -> MEM -> WB and decodes the datapath strobes
//                from the state and the latched instruction register.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state changes on rising edge
//    rst          in   synchronous active-high reset
//    instr[31:0]  in   instruction word, captured in FETCH when mem_ready=1
//    mem_ready    in   memory handshake (FETCH and MEM)
//    zero         in   ALU zero flag (EXECUTE, BEQ only)
//    alu_op[3:0]  out  ALU operation code
//    alu_src      out  operand-2 select: 0=rs2, 1=immediate
//    ir_write     out  load instruction register
//    pc_write     out  advance program counter
//    mem_read     out  memory read strobe
//    mem_write    out  memory write strobe
//    reg_write    out  register file write strobe
//    mem_to_reg   out  write-back source select: 1=memory data
//    branch_taken out  BEQ taken (combinational from zero in EXECUTE)
//    illegal      out  one-cycle pulse on an unsupported instruction
//    retire       out  one-cycle pulse in the last cycle of a legal instr
// ============================================================================
module mc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        branch_taken,
    output logic        illegal,
    output logic        retire
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_LT  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL = 4'b1000;
    localparam logic [3:0] c_ALU_SLL = 4'b1001;
    localparam logic [3:0] c_ALU_SRA = 4'b1010;
    localparam logic [3:0] c_ALU_XOR = 4'b0101;

    localparam logic [6:0] c_OPC_R   = 7'b0110011;
    localparam logic [6:0] c_OPC_I   = 7'b0010011;
    localparam logic [6:0] c_OPC_LW  = 7'b0000011;
    localparam logic [6:0] c_OPC_SW  = 7'b0100011;
    localparam logic [6:0] c_OPC_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;

    // ------------------------------------------------------------------
    // Instruction field decode (from the latched IR only)
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_bit30;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq;
    logic       w_legal;
    logic [3:0] w_exec_op;
    logic       w_exec_src;
    logic       w_ir_unused;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_bit30  = r_ir[30];

    // Register/immediate/offset fields belong to the datapath, not here.
    assign w_ir_unused = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

    assign w_is_r   = (w_opcode == c_OPC_R);
    assign w_is_i   = (w_opcode == c_OPC_I);
    assign w_is_lw  = (w_opcode == c_OPC_LW);
    assign w_is_sw  = (w_opcode == c_OPC_SW);
    assign w_is_beq = (w_opcode == c_OPC_BEQ);

    // funct3=011 (sltu) is outside the supported subset for R/I-ALU.
    assign w_legal = ((w_is_r || w_is_i) && (w_funct3 != 3'b011))
                  || ((w_is_lw || w_is_sw) && (w_funct3 == 3'b010))
                  || (w_is_beq && (w_funct3 == 3'b000));

    // ALU operation for the latched instruction. Only legal instructions
    // ever reach EXECUTE/MEM/WB, so illegal encodings need no special case.
    always_comb begin
        w_exec_op  = c_ALU_ADD;
        w_exec_src = 1'b0;
        if (w_is_lw || w_is_sw) begin
            w_exec_op  = c_ALU_ADD;
            w_exec_src = 1'b1;
        end else if (w_is_beq) begin
            w_exec_op  = c_ALU_SUB;
            w_exec_src = 1'b0;
        end else begin
            w_exec_src = w_is_i;
            case (w_funct3)
                // addi ignores IR[30]: only R-type can subtract here
                3'b000:  w_exec_op = (w_is_r && w_bit30) ? c_ALU_SUB : c_ALU_ADD;
                3'b001:  w_exec_op = c_ALU_SLL;
                3'b010:  w_exec_op = c_ALU_LT;
                3'b100:  w_exec_op = c_ALU_XOR;
                3'b101:  w_exec_op = w_bit30 ? c_ALU_SRA : c_ALU_SRL;
                3'b110:  w_exec_op = c_ALU_OR;
                3'b111:  w_exec_op = c_ALU_AND;
                default: w_exec_op = c_ALU_ADD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && mem_ready) begin
                r_ir <= instr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Everything is forced idle while rst is
    // high so an in-flight memory access is dropped in the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        alu_op       = c_ALU_ADD;
        alu_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        retire       = 1'b0;

        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next = S_EXECUTE;
                    end else begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    alu_op  = w_exec_op;
                    alu_src = w_exec_src;
                    if (w_is_beq) begin
                        branch_taken = zero;
                        retire       = 1'b1;
                        w_next       = S_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_MEM: begin
                    alu_op    = w_exec_op;
                    alu_src   = w_exec_src;
                    mem_read  = w_is_lw;
                    mem_write = w_is_sw;
                    if (mem_ready) begin
                        if (w_is_lw) begin
                            w_next = S_WB;
                        end else begin
                            retire = 1'b1;
                            w_next = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    alu_op     = w_exec_op;
                    alu_src    = w_exec_src;
                    reg_write  = 1'b1;
                    mem_to_reg = w_is_lw;
                    retire     = 1'b1;
                    w_next     = S_FETCH;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Self-checking bench for mc_control. Each instruction is
//                expanded into its list of phases (fetch stalls, decode,
//                execute, memory stalls, write-back) and the expected
//                outputs of every cycle are derived from the phase and the
//                instruction class. A directed prologue pins known cases,
//                then randomized instructions, stalls and resets follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch_taken;
        logic       illegal;
        logic       retire;
    } outs_t;

    localparam int K_ILL = 0;
    localparam int K_R   = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [3:0]  alu_op;
    logic        alu_src, ir_write, pc_write, mem_read, mem_write;
    logic        reg_write, mem_to_reg, branch_taken, illegal, retire;

    outs_t obs;
    outs_t exp_o;
    logic  chk_en;
    logic  chk_src;
    byte   cur_ph;
    outs_t lg [0:31];
    int    n_cmp;
    int    n_err;

    mc_control dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .retire       (retire)
    );

    assign obs = {alu_op, alu_src, ir_write, pc_write, mem_read, mem_write,
                  reg_write, mem_to_reg, branch_taken, illegal, retire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    function automatic int kind_of(input logic [31:0] x);
        logic [2:0] f3;
        f3 = x[14:12];
        case (x[6:0])
            7'b0110011: return (f3 == 3'b011) ? K_ILL : K_R;
            7'b0010011: return (f3 == 3'b011) ? K_ILL : K_I;
            7'b0000011: return (f3 == 3'b010) ? K_LW  : K_ILL;
            7'b0100011: return (f3 == 3'b010) ? K_SW  : K_ILL;
            7'b1100011: return (f3 == 3'b000) ? K_BEQ : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] op_of(input logic [31:0] x);
        int k;
        k = kind_of(x);
        if (k == K_LW || k == K_SW) return 4'b0010;
        if (k == K_BEQ)             return 4'b0110;
        case (x[14:12])
            3'b000:  return (k == K_R && x[30]) ? 4'b0110 : 4'b0010;
            3'b001:  return 4'b1001;
            3'b010:  return 4'b0100;
            3'b100:  return 4'b0101;
            3'b101:  return x[30] ? 4'b1010 : 4'b1000;
            3'b110:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // ---------------- the single compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            outs_t g;
            g = obs;
            if (!chk_src) g.alu_src = exp_o.alu_src;
            n_cmp++;
            if (g !== exp_o) begin
                n_err++;
                $display("FAIL cycle-check phase %c t=%0t: got %b expected %b (alu_op,src,irw,pcw,mrd,mwr,rw,m2r,bt,ill,ret)",
                         cur_ph, $time, g, exp_o);
            end
        end
    end

    task automatic lit(input string nm, input int got, input int ex);
        n_cmp++;
        if (got != ex) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, ex);
        end
    endtask

    // Runs one instruction from its first FETCH cycle. sf/sm are the stall
    // counts in FETCH/MEM, zv the zero flag in EXECUTE, rst_at the phase
    // index at which reset is asserted for one cycle (-1 for none).
    task automatic run_instr(input logic [31:0] ins, input int sf, input int sm,
                             input logic zv, input int rst_at);
        int    k;
        byte   ph[$];
        logic  rdy[$];
        outs_t e;
        bit    stop;
        k = kind_of(ins);
        for (int i = 0; i <= sf; i++) begin ph.push_back("F"); rdy.push_back(i == sf); end
        ph.push_back("D"); rdy.push_back(1'($urandom_range(0, 1)));
        if (k != K_ILL) begin ph.push_back("E"); rdy.push_back(1'($urandom_range(0, 1))); end
        if (k == K_LW || k == K_SW)
            for (int i = 0; i <= sm; i++) begin ph.push_back("M"); rdy.push_back(i == sm); end
        if (k == K_R || k == K_I || k == K_LW) begin ph.push_back("W"); rdy.push_back(1'($urandom_range(0, 1))); end

        stop = 1'b0;
        for (int c = 0; c < ph.size() && !stop; c++) begin
            instr     = (ph[c] == "F") ? ins : $urandom;
            mem_ready = rdy[c];
            zero      = (ph[c] == "E") ? zv : 1'($urandom_range(0, 1));
            e         = '0;
            e.alu_op  = 4'b0010;
            chk_src   = 1'b0;
            if (c == rst_at) begin
                rst    = 1'b1;
                cur_ph = "R";
                stop   = 1'b1;
            end else begin
                rst    = 1'b0;
                cur_ph = ph[c];
                case (ph[c])
                    "F": begin
                        e.mem_read = 1'b1;
                        e.ir_write = rdy[c];
                        e.pc_write = rdy[c];
                    end
                    "D": e.illegal = (k == K_ILL);
                    "E": begin
                        e.alu_op       = op_of(ins);
                        e.alu_src      = (k == K_I || k == K_LW || k == K_SW);
                        chk_src        = 1'b1;
                        e.branch_taken = (k == K_BEQ) && zv;
                        e.retire       = (k == K_BEQ);
                    end
                    "M": begin
                        e.alu_op    = op_of(ins);
                        e.mem_read  = (k == K_LW);
                        e.mem_write = (k == K_SW);
                        e.retire    = (k == K_SW) && rdy[c];
                    end
                    default: begin
                        e.alu_op     = op_of(ins);
                        e.reg_write  = 1'b1;
                        e.mem_to_reg = (k == K_LW);
                        e.retire     = 1'b1;
                    end
                endcase
            end
            exp_o  = e;
            chk_en = 1'b1;
            #3;
            if (c < 32) lg[c] = obs;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = $urandom_range(0, 6);
        case (sel)
            0: x[6:0] = 7'b0110011;
            1: x[6:0] = 7'b0010011;
            2: begin x[6:0] = 7'b0000011; if ($urandom_range(0, 3) != 0) x[14:12] = 3'b010; end
            3: begin x[6:0] = 7'b0100011; if ($urandom_range(0, 3) != 0) x[14:12] = 3'b010; end
            4: begin x[6:0] = 7'b1100011; if ($urandom_range(0, 3) != 0) x[14:12] = 3'b000; end
            5: ;
            default: x = 32'h0000_0000;
        endcase
        return x;
    endfunction

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        chk_en    = 1'b0;
        chk_src   = 1'b0;
        cur_ph    = "R";
        exp_o     = '0;
        rst       = 1'b1;
        instr     = 32'h0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        @(posedge clk);
        #1;

        // Reset cycle with mem_ready high: reset must win.
        run_instr(32'h002081B3, 0, 0, 1'b0, 0);
        lit("reset_mem_read", int'(lg[0].mem_read), 0);
        lit("reset_alu_op",   int'(lg[0].alu_op),   2);

        // add
        run_instr(32'h002081B3, 0, 0, 1'b0, -1);
        lit("post_reset_fetch_mem_read", int'(lg[0].mem_read),  1);
        lit("add_alu_op_c3",             int'(lg[2].alu_op),    2);
        lit("add_alu_src_c3",            int'(lg[2].alu_src),   0);
        lit("add_reg_write_c4",          int'(lg[3].reg_write), 1);
        lit("add_retire_c4",             int'(lg[3].retire),    1);

        // sub, srai
        run_instr(32'h402081B3, 0, 0, 1'b0, -1);
        lit("sub_alu_op", int'(lg[2].alu_op), 6);
        run_instr(32'h4030D293, 0, 0, 1'b0, -1);
        lit("srai_alu_op",  int'(lg[2].alu_op),  10);
        lit("srai_alu_src", int'(lg[2].alu_src), 1);

        // beq taken / not taken
        run_instr(32'h00208463, 0, 0, 1'b1, -1);
        lit("beq1_branch_taken", int'(lg[2].branch_taken), 1);
        lit("beq1_alu_op",       int'(lg[2].alu_op),       6);
        lit("beq1_retire",       int'(lg[2].retire),       1);
        run_instr(32'h00208463, 0, 0, 1'b0, -1);
        lit("beq0_branch_taken", int'(lg[2].branch_taken), 0);
        lit("beq0_retire",       int'(lg[2].retire),       1);

        // lw with three MEM stall cycles
        run_instr(32'h0000A183, 0, 3, 1'b0, -1);
        lit("lw_mem_read_stall", int'(lg[4].mem_read),   1);
        lit("lw_reg_write_c8",   int'(lg[7].reg_write),  1);
        lit("lw_mem_to_reg_c8",  int'(lg[7].mem_to_reg), 1);
        lit("lw_no_wb_in_mem",   int'(lg[6].reg_write),  0);

        // all-zero word is illegal
        run_instr(32'h00000000, 0, 0, 1'b0, -1);
        lit("ill_pulse",     int'(lg[1].illegal),   1);
        lit("ill_no_retire", int'(lg[1].retire),    0);
        lit("ill_no_rw",     int'(lg[1].reg_write), 0);

        // sw, reset in the second MEM cycle
        run_instr(32'h0020A223, 0, 2, 1'b0, 4);
        lit("sw_mem_write_before_rst", int'(lg[3].mem_write), 1);
        lit("sw_mem_write_in_rst",     int'(lg[4].mem_write), 0);
        run_instr(32'h002081B3, 0, 0, 1'b0, -1);
        lit("after_rst_fetch", int'(lg[0].mem_read), 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int ra;
            ra = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), ra);
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
